// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared async SRAM: VGA pixel reads (high priority) and
// sprite/tile loader reads/writes, with a bounded-starvation guarantee for the loader.
module sram_arbiter #(
   parameter int RD_WAIT    = 1,
   parameter int WR_WAIT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        vid_req,
   input  logic [19:0] vid_addr,
   output logic        vid_gnt,
   output logic        vid_rvalid,
   output logic [15:0] vid_rdata,
   input  logic        ld_req,
   input  logic        ld_we,
   input  logic [19:0] ld_addr,
   input  logic [15:0] ld_wdata,
   input  logic [1:0]  ld_be,
   output logic        ld_gnt,
   output logic        ld_done,
   output logic [15:0] ld_rdata,
   output logic [19:0] SRAM_ADDR,
   inout  wire  [15:0] SRAM_DQ,
   output logic        SRAM_CE_N,
   output logic        SRAM_OE_N,
   output logic        SRAM_WE_N,
   output logic        SRAM_UB_N,
   output logic        SRAM_LB_N
);

   localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int CNT_W    = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT + 1);
   localparam int STV_W    = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);

   typedef enum logic [2:0] {
      IDLE,
      RD,
      WR_SETUP,
      WR_PULSE,
      WR_HOLD
   } state_t;

   state_t             state;
   logic [CNT_W-1:0]   cnt;
   logic [STV_W-1:0]   starve_cnt;
   logic               owner_ld;
   logic               dq_oe;
   logic [15:0]        dq_out;
   logic               ld_wins;

   // The bus is driven only between WR_SETUP and WR_HOLD; reset clears dq_oe asynchronously.
   assign SRAM_DQ = dq_oe ? dq_out : 16'hzzzz;

   assign ld_wins = ld_req && (!vid_req || (starve_cnt == STV_W'(STARVE_MAX)));
   assign ld_gnt  = !Reset && (state == IDLE) && ld_wins;
   assign vid_gnt = !Reset && (state == IDLE) && vid_req && !ld_wins;

   // Counts video grants taken while the loader is waiting; saturates so the loader wins next.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         starve_cnt <= '0;
      end else if (!ld_req || ld_gnt) begin
         starve_cnt <= '0;
      end else if (vid_gnt && (starve_cnt != STV_W'(STARVE_MAX))) begin
         starve_cnt <= starve_cnt + 1'b1;
      end
   end

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state      <= IDLE;
         cnt        <= '0;
         owner_ld   <= 1'b0;
         dq_oe      <= 1'b0;
         dq_out     <= '0;
         SRAM_ADDR  <= '0;
         SRAM_CE_N  <= 1'b1;
         SRAM_OE_N  <= 1'b1;
         SRAM_WE_N  <= 1'b1;
         SRAM_UB_N  <= 1'b1;
         SRAM_LB_N  <= 1'b1;
         vid_rvalid <= 1'b0;
         vid_rdata  <= '0;
         ld_done    <= 1'b0;
         ld_rdata   <= '0;
      end else begin
         vid_rvalid <= 1'b0;
         ld_done    <= 1'b0;
         case (state)
            IDLE: begin
               // Strobes are registered, so the grant edge already sets up the first access cycle.
               if (vid_gnt || ld_gnt) begin
                  owner_ld               <= ld_gnt;
                  SRAM_ADDR              <= ld_gnt ? ld_addr : vid_addr;
                  SRAM_CE_N              <= 1'b0;
                  {SRAM_UB_N, SRAM_LB_N} <= ld_gnt ? ~ld_be : 2'b00;
                  if (ld_gnt && ld_we) begin
                     dq_out <= ld_wdata;
                     dq_oe  <= 1'b1;
                     state  <= WR_SETUP;
                  end else begin
                     SRAM_OE_N <= 1'b0;
                     cnt       <= CNT_W'(RD_WAIT);
                     state     <= RD;
                  end
               end
            end
            RD: begin
               if (cnt == '0) begin
                  if (owner_ld) begin
                     ld_rdata <= SRAM_DQ;
                     ld_done  <= 1'b1;
                  end else begin
                     vid_rdata  <= SRAM_DQ;
                     vid_rvalid <= 1'b1;
                  end
                  SRAM_CE_N <= 1'b1;
                  SRAM_OE_N <= 1'b1;
                  SRAM_UB_N <= 1'b1;
                  SRAM_LB_N <= 1'b1;
                  state     <= IDLE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WR_SETUP: begin
               SRAM_WE_N <= 1'b0;
               cnt       <= CNT_W'(WR_WAIT);
               state     <= WR_PULSE;
            end
            WR_PULSE: begin
               if (cnt == '0) begin
                  SRAM_WE_N <= 1'b1;
                  state     <= WR_HOLD;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WR_HOLD: begin
               dq_oe     <= 1'b0;
               SRAM_CE_N <= 1'b1;
               SRAM_UB_N <= 1'b1;
               SRAM_LB_N <= 1'b1;
               ld_done   <= 1'b1;
               state     <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: directed protocol scenarios plus a randomized run checked
// against a transaction-level model of arbitration, latency and memory contents.
module tb_sram_arbiter;

   localparam int RD_WAIT    = 1;
   localparam int WR_WAIT    = 1;
   localparam int STARVE_MAX = 4;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        vid_req;
   logic [19:0] vid_addr;
   logic        vid_gnt;
   logic        vid_rvalid;
   logic [15:0] vid_rdata;
   logic        ld_req;
   logic        ld_we;
   logic [19:0] ld_addr;
   logic [15:0] ld_wdata;
   logic [1:0]  ld_be;
   logic        ld_gnt;
   logic        ld_done;
   logic [15:0] ld_rdata;
   logic [19:0] SRAM_ADDR;
   wire  [15:0] SRAM_DQ;
   logic        SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N;
   logic [4:0]  strb;

   int checks   = 0;
   int failures = 0;

   sram_arbiter #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT), .STARVE_MAX(STARVE_MAX)) dut (
      .Clk(Clk), .Reset(Reset),
      .vid_req(vid_req), .vid_addr(vid_addr), .vid_gnt(vid_gnt),
      .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
      .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata), .ld_be(ld_be),
      .ld_gnt(ld_gnt), .ld_done(ld_done), .ld_rdata(ld_rdata),
      .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(SRAM_DQ),
      .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N),
      .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N)
   );

   always #5 Clk = ~Clk;

   assign strb = {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N};

   // SRAM model: 4K words, aliased on the low 12 address bits.
   logic [15:0] sram [0:4095];
   logic        poke_en = 1'b0;
   logic [11:0] poke_a  = '0;
   logic [15:0] poke_d  = '0;

   assign SRAM_DQ = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ? sram[SRAM_ADDR[11:0]] : 16'hzzzz;

   always @(negedge Clk) begin
      if (poke_en) begin
         sram[poke_a] = poke_d;
      end else if (!SRAM_CE_N && !SRAM_WE_N) begin
         if (!SRAM_LB_N) sram[SRAM_ADDR[11:0]][7:0]  = SRAM_DQ[7:0];
         if (!SRAM_UB_N) sram[SRAM_ADDR[11:0]][15:8] = SRAM_DQ[15:8];
      end
   end

   task automatic poke(input logic [11:0] a, input logic [15:0] d);
      @(posedge Clk); #1;
      poke_en = 1'b1; poke_a = a; poke_d = d;
      @(posedge Clk); #1;
      poke_en = 1'b0;
   endtask

   task automatic test_reset();
      Reset = 1'b1;
      vid_req = 1'b0; vid_addr = '0;
      ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0; ld_be = '0;
      repeat (3) @(posedge Clk);
      @(negedge Clk);
      checks++; if (strb !== 5'h1F) begin failures++; $display("FAIL reset_strobes got=%b exp=%b", strb, 5'h1F); end
      checks++; if (SRAM_ADDR !== 20'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", SRAM_ADDR); end
      checks++; if ({vid_rvalid, ld_done} !== 2'b00) begin failures++; $display("FAIL reset_pulses got=%b exp=00", {vid_rvalid, ld_done}); end
      checks++; if ({vid_rdata, ld_rdata} !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", {vid_rdata, ld_rdata}); end
      vid_req = 1'b1; ld_req = 1'b1;
      #1;
      checks++; if ({vid_gnt, ld_gnt} !== 2'b00) begin failures++; $display("FAIL reset_gnt got=%b exp=00", {vid_gnt, ld_gnt}); end
      vid_req = 1'b0; ld_req = 1'b0;
      @(posedge Clk); #1;
      Reset = 1'b0;
   endtask

   task automatic test_video_read();
      logic [4:0] es [0:4];
      es = '{5'h1F, 5'b00100, 5'b00100, 5'h1F, 5'h1F};
      poke(12'h421, 16'hBEEF);
      for (int c = 0; c < 5; c++) begin
         @(posedge Clk); #1;
         vid_req  = (c == 0);
         vid_addr = (c == 0) ? 20'h00421 : 20'($urandom);
         @(negedge Clk);
         checks++; if (vid_gnt !== (c == 0)) begin failures++; $display("FAIL vrd_gnt c=%0d got=%b exp=%b", c, vid_gnt, (c == 0)); end
         checks++; if (strb !== es[c]) begin failures++; $display("FAIL vrd_strobes c=%0d got=%b exp=%b", c, strb, es[c]); end
         checks++; if (vid_rvalid !== (c == 3)) begin failures++; $display("FAIL vrd_rvalid c=%0d got=%b exp=%b", c, vid_rvalid, (c == 3)); end
         if (c == 1 || c == 2) begin
            checks++; if (SRAM_ADDR !== 20'h00421) begin failures++; $display("FAIL vrd_addr c=%0d got=%h exp=00421", c, SRAM_ADDR); end
         end
         if (c >= 3) begin
            checks++; if (vid_rdata !== 16'hBEEF) begin failures++; $display("FAIL vrd_data c=%0d got=%h exp=BEEF", c, vid_rdata); end
         end
      end
   endtask

   task automatic test_loader_write();
      logic [4:0] es [0:6];
      int         we_low;
      es = '{5'h1F, 5'b01110, 5'b01010, 5'b01010, 5'b01110, 5'h1F, 5'h1F};
      we_low = 0;
      poke(12'h345, 16'h1234);
      for (int c = 0; c < 7; c++) begin
         @(posedge Clk); #1;
         ld_req   = (c == 0);
         ld_we    = (c == 0) ? 1'b1 : 1'($urandom);
         ld_addr  = (c == 0) ? 20'h12345 : 20'($urandom);
         ld_wdata = (c == 0) ? 16'hA5C3 : 16'($urandom);
         ld_be    = (c == 0) ? 2'b01 : 2'($urandom);
         @(negedge Clk);
         if (!SRAM_WE_N) we_low++;
         checks++; if (ld_gnt !== (c == 0)) begin failures++; $display("FAIL lwr_gnt c=%0d got=%b exp=%b", c, ld_gnt, (c == 0)); end
         checks++; if (strb !== es[c]) begin failures++; $display("FAIL lwr_strobes c=%0d got=%b exp=%b", c, strb, es[c]); end
         checks++; if (ld_done !== (c == 5)) begin failures++; $display("FAIL lwr_done c=%0d got=%b exp=%b", c, ld_done, (c == 5)); end
         if (c >= 1 && c <= 4) begin
            checks++; if (SRAM_DQ !== 16'hA5C3) begin failures++; $display("FAIL lwr_dq c=%0d got=%h exp=A5C3", c, SRAM_DQ); end
            checks++; if (SRAM_ADDR !== 20'h12345) begin failures++; $display("FAIL lwr_addr c=%0d got=%h exp=12345", c, SRAM_ADDR); end
         end
      end
      checks++; if (we_low != WR_WAIT + 1) begin failures++; $display("FAIL lwr_we_width got=%0d exp=%0d", we_low, WR_WAIT + 1); end
      checks++; if (sram[12'h345] !== 16'h12C3) begin failures++; $display("FAIL lwr_mem got=%h exp=12C3", sram[12'h345]); end
   endtask

   task automatic test_loader_read();
      logic [4:0] es [0:4];
      int         oe_low;
      es = '{5'h1F, 5'b00101, 5'b00101, 5'h1F, 5'h1F};
      oe_low = 0;
      poke(12'hBCD, 16'h7E00);
      for (int c = 0; c < 5; c++) begin
         @(posedge Clk); #1;
         ld_req  = (c == 0);
         ld_we   = 1'b0;
         ld_addr = (c == 0) ? 20'h0ABCD : 20'($urandom);
         ld_be   = (c == 0) ? 2'b10 : 2'($urandom);
         @(negedge Clk);
         if (!SRAM_OE_N) oe_low++;
         checks++; if (ld_gnt !== (c == 0)) begin failures++; $display("FAIL lrd_gnt c=%0d got=%b exp=%b", c, ld_gnt, (c == 0)); end
         checks++; if (strb !== es[c]) begin failures++; $display("FAIL lrd_strobes c=%0d got=%b exp=%b", c, strb, es[c]); end
         checks++; if ({vid_rvalid, ld_done} !== {1'b0, (c == 3)}) begin failures++; $display("FAIL lrd_pulses c=%0d got=%b exp=%b", c, {vid_rvalid, ld_done}, {1'b0, (c == 3)}); end
         if (c == 3) begin
            checks++; if (ld_rdata !== 16'h7E00) begin failures++; $display("FAIL lrd_data got=%h exp=7E00", ld_rdata); end
         end
      end
      checks++; if (oe_low != RD_WAIT + 1) begin failures++; $display("FAIL lrd_oe_width got=%0d exp=%0d", oe_low, RD_WAIT + 1); end
   endtask

   task automatic test_starvation();
      int   ng, nrv, ndone;
      logic exp_l;
      ng = 0; nrv = 0; ndone = 0;
      for (int c = 0; c < 80 && ng < 10; c++) begin
         @(posedge Clk); #1;
         vid_req = 1'b1; vid_addr = 20'h00421;
         ld_req = 1'b1; ld_we = 1'b0; ld_addr = 20'h0ABCD; ld_be = 2'b11;
         @(negedge Clk);
         if (vid_rvalid) begin
            nrv++;
            checks++; if (vid_rdata !== 16'hBEEF) begin failures++; $display("FAIL stv_vdata got=%h exp=BEEF", vid_rdata); end
         end
         if (ld_done) begin
            ndone++;
            checks++; if (ld_rdata !== 16'h7E00) begin failures++; $display("FAIL stv_ldata got=%h exp=7E00", ld_rdata); end
         end
         if (vid_gnt || ld_gnt) begin
            exp_l = ((ng % (STARVE_MAX + 1)) == STARVE_MAX);
            checks++;
            if ({vid_gnt, ld_gnt} !== {!exp_l, exp_l}) begin
               failures++; $display("FAIL stv_order grant=%0d got_v_l=%b exp_v_l=%b", ng, {vid_gnt, ld_gnt}, {!exp_l, exp_l});
            end
            ng++;
         end
      end
      for (int c = 0; c < 6; c++) begin
         @(posedge Clk); #1;
         vid_req = 1'b0; ld_req = 1'b0;
         @(negedge Clk);
         if (vid_rvalid) nrv++;
         if (ld_done) ndone++;
      end
      checks++; if (ng != 10) begin failures++; $display("FAIL stv_grants got=%0d exp=10", ng); end
      checks++; if (nrv != 10 - 10 / (STARVE_MAX + 1)) begin failures++; $display("FAIL stv_rvalid_count got=%0d exp=%0d", nrv, 10 - 10 / (STARVE_MAX + 1)); end
      checks++; if (ndone != 10 / (STARVE_MAX + 1)) begin failures++; $display("FAIL stv_done_count got=%0d exp=%0d", ndone, 10 / (STARVE_MAX + 1)); end
   endtask

   task automatic test_reset_mid_write();
      poke(12'h777, 16'h1111);
      @(posedge Clk); #1;
      ld_req = 1'b1; ld_we = 1'b1; ld_addr = 20'h00777; ld_wdata = 16'hFFFF; ld_be = 2'b11;
      @(negedge Clk);
      checks++; if (ld_gnt !== 1'b1) begin failures++; $display("FAIL rst_wr_gnt got=%b exp=1", ld_gnt); end
      @(posedge Clk); #1;
      ld_req = 1'b0;
      @(posedge Clk); #1;
      checks++; if ({SRAM_CE_N, SRAM_WE_N} !== 2'b00) begin failures++; $display("FAIL rst_wr_pulse got=%b exp=00", {SRAM_CE_N, SRAM_WE_N}); end
      #2 Reset = 1'b1;
      #1;
      checks++; if (strb !== 5'h1F) begin failures++; $display("FAIL rst_async_strobes got=%b exp=%b", strb, 5'h1F); end
      repeat (2) begin
         @(negedge Clk);
         checks++; if (ld_done !== 1'b0) begin failures++; $display("FAIL rst_hold_done got=%b exp=0", ld_done); end
      end
      @(posedge Clk); #1;
      Reset = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge Clk);
         checks++; if ({ld_done, strb} !== {1'b0, 5'h1F}) begin failures++; $display("FAIL rst_after c=%0d got=%b exp=%b", c, {ld_done, strb}, {1'b0, 5'h1F}); end
      end
      test_video_read();
   endtask

   task automatic test_video_stream();
      logic [15:0] sd [0:3];
      int          vi, due;
      logic        pend, exp_g, exp_rv;
      for (int i = 0; i < 4; i++) begin
         sd[i] = 16'($urandom);
         poke(12'h100 + 12'(i), sd[i]);
      end
      vi = 0; pend = 1'b0; due = 0; exp_g = 1'b0;
      for (int c = 0; c < 32; c++) begin
         @(posedge Clk); #1;
         if (exp_g) vi = (vi + 1) % 4;
         vid_req  = (c < 24);
         vid_addr = (c < 24) ? (20'h00100 + 20'(vi)) : 20'($urandom);
         @(negedge Clk);
         exp_rv = pend && (c == due);
         checks++; if (vid_rvalid !== exp_rv) begin failures++; $display("FAIL vst_rvalid c=%0d got=%b exp=%b", c, vid_rvalid, exp_rv); end
         if (exp_rv) begin
            checks++; if (vid_rdata !== sd[(vi + 3) % 4]) begin failures++; $display("FAIL vst_data c=%0d got=%h exp=%h", c, vid_rdata, sd[(vi + 3) % 4]); end
            pend = 1'b0;
         end
         exp_g = vid_req && !pend;
         checks++; if (vid_gnt !== exp_g) begin failures++; $display("FAIL vst_gnt c=%0d got=%b exp=%b", c, vid_gnt, exp_g); end
         if (!pend) begin
            checks++; if (SRAM_CE_N !== 1'b1) begin failures++; $display("FAIL vst_idle_ce c=%0d got=%b exp=1", c, SRAM_CE_N); end
         end
         if (exp_g) begin
            pend = 1'b1;
            due  = c + RD_WAIT + 2;
         end
      end
   endtask

   task automatic test_random();
      logic [19:0] at [0:15];
      logic [15:0] rm [0:15];
      logic [19:0] p_addr;
      logic [1:0]  p_ubl;
      logic [15:0] exp_d;
      logic        l_rd, ld_w, exp_vg, exp_lg, vg_prev, lg_prev;
      int          pend, due, vi, li, waited;
      for (int i = 0; i < 16; i++) begin
         at[i] = {8'($urandom), 12'hC00 + 12'(i)};
         rm[i] = 16'($urandom);
         poke(at[i][11:0], rm[i]);
      end
      pend = 0; due = 0; vi = 0; li = 0; waited = 0;
      vg_prev = 1'b0; lg_prev = 1'b0; l_rd = 1'b0; exp_d = '0; p_addr = '0; p_ubl = '0;
      for (int c = 0; c < 400; c++) begin
         @(posedge Clk); #1;
         if (vg_prev) vid_req = 1'b0;
         if (lg_prev) ld_req = 1'b0;
         if (!vid_req && c < 380 && $urandom_range(0, 2) == 0) begin
            vid_req = 1'b1; vi = $urandom_range(0, 15); vid_addr = at[vi];
         end else if (!vid_req) begin
            vid_addr = 20'($urandom);
         end
         if (!ld_req && c < 380 && $urandom_range(0, 3) == 0) begin
            ld_req = 1'b1; li = $urandom_range(0, 15); ld_addr = at[li];
            ld_we = 1'($urandom); ld_be = 2'($urandom); ld_wdata = 16'($urandom);
            waited = 0;
         end else if (!ld_req) begin
            ld_addr = 20'($urandom); ld_we = 1'($urandom); ld_be = 2'($urandom); ld_wdata = 16'($urandom);
         end
         @(negedge Clk);
         checks++; if (vid_rvalid !== (pend == 1 && c == due)) begin failures++; $display("FAIL rnd_rvalid c=%0d got=%b exp=%b", c, vid_rvalid, (pend == 1 && c == due)); end
         checks++; if (ld_done !== (pend == 2 && c == due)) begin failures++; $display("FAIL rnd_done c=%0d got=%b exp=%b", c, ld_done, (pend == 2 && c == due)); end
         if (pend == 1 && c == due) begin
            checks++; if (vid_rdata !== exp_d) begin failures++; $display("FAIL rnd_vdata c=%0d got=%h exp=%h", c, vid_rdata, exp_d); end
         end
         if (pend == 2 && c == due && l_rd) begin
            checks++; if (ld_rdata !== exp_d) begin failures++; $display("FAIL rnd_ldata c=%0d got=%h exp=%h", c, ld_rdata, exp_d); end
         end
         if (pend != 0 && c == due) pend = 0;
         if (pend != 0) begin
            checks++;
            if ({SRAM_CE_N, SRAM_ADDR, SRAM_UB_N, SRAM_LB_N} !== {1'b0, p_addr, p_ubl}) begin
               failures++; $display("FAIL rnd_access c=%0d got=%b_%h_%b exp=0_%h_%b", c, SRAM_CE_N, SRAM_ADDR, {SRAM_UB_N, SRAM_LB_N}, p_addr, p_ubl);
            end
         end else begin
            checks++; if (SRAM_CE_N !== 1'b1) begin failures++; $display("FAIL rnd_idle_ce c=%0d got=%b exp=1", c, SRAM_CE_N); end
         end
         ld_w   = ld_req && (!vid_req || waited >= STARVE_MAX);
         exp_lg = (pend == 0) && ld_w;
         exp_vg = (pend == 0) && vid_req && !ld_w;
         checks++; if ({vid_gnt, ld_gnt} !== {exp_vg, exp_lg}) begin failures++; $display("FAIL rnd_gnt c=%0d got_v_l=%b exp_v_l=%b", c, {vid_gnt, ld_gnt}, {exp_vg, exp_lg}); end
         if (exp_vg) begin
            pend = 1; due = c + RD_WAIT + 2; p_addr = at[vi]; p_ubl = 2'b00; exp_d = rm[vi];
            if (ld_req) waited++;
         end
         if (exp_lg) begin
            pend = 2; p_addr = at[li]; p_ubl = ~ld_be; l_rd = !ld_we;
            if (ld_we) begin
               due = c + WR_WAIT + 4;
               if (ld_be[0]) rm[li][7:0]  = ld_wdata[7:0];
               if (ld_be[1]) rm[li][15:8] = ld_wdata[15:8];
            end else begin
               due = c + RD_WAIT + 2; exp_d = rm[li];
            end
         end
         vg_prev = exp_vg; lg_prev = exp_lg;
      end
      checks++; if (pend != 0) begin failures++; $display("FAIL rnd_drain pending=%0d exp=0", pend); end
      vid_req = 1'b0; ld_req = 1'b0;
   endtask

   initial begin
      test_reset();
      test_video_read();
      test_loader_write();
      test_loader_read();
      test_starvation();
      test_reset_mid_write();
      test_video_stream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
